// File: rtl/sm_driver_pkg.sv
// Shared definitions for the sm_driver counter initiator: one-hot state
// encodings and the watchdog limit used when SM_DRIVER_TIMEOUT_EN is defined.
package sm_driver_pkg;

    localparam int STATE_W = 6;

    localparam logic [STATE_W-1:0] ST_IDLE  = 6'b000001;
    localparam logic [STATE_W-1:0] ST_ARM   = 6'b000010;
    localparam logic [STATE_W-1:0] ST_RUN   = 6'b000100;
    localparam logic [STATE_W-1:0] ST_CHECK = 6'b001000;
    localparam logic [STATE_W-1:0] ST_DONE  = 6'b010000;
    localparam logic [STATE_W-1:0] ST_ERR   = 6'b100000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_ARM   = ST_ARM,
        S_RUN   = ST_RUN,
        S_CHECK = ST_CHECK,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } state_t;

    // A healthy move needs at most 2^W cycles in ARM/RUN, so two spare cycles
    // of slack separate a slow counter from a dead one.
    function automatic int wdog_limit(input int counter_width);
        return (1 << counter_width) + 2;
    endfunction

endpackage

// File: rtl/sm_driver_wdog.sv
// Watchdog for sm_driver: counts cycles spent in ARM/RUN and flags expiry when
// the count would reach the package limit. Only built under SM_DRIVER_TIMEOUT_EN.
module sm_driver_wdog
    import sm_driver_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = COUNTER_WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(wdog_limit(COUNTER_WIDTH) - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry fires in the cycle whose increment would reach the limit, so
    // the FSM lands in ERR exactly when the limit is reached.
    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/sm_driver.sv
// Drives an up/down counter's act/up_dwn_n until its count lands on a requested
// target, then verifies it. Optional watchdog: define SM_DRIVER_TIMEOUT_EN.
module sm_driver
    import sm_driver_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [COUNTER_WIDTH-1:0] req_target,
    output logic                     req_ready,
    input  logic [COUNTER_WIDTH-1:0] count_in,
    input  logic                     ovflw_in,
    output logic                     act,
    output logic                     up_dwn_n,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t                   state;
    state_t                   next_state;
    logic [COUNTER_WIDTH-1:0] target_q;
    logic                     dir_q;
    logic [COUNTER_WIDTH-1:0] step_val;
    logic                     last;

    // The count the counter will hold after this cycle's step; matching the
    // target means act must drop now so the counter idles on that value.
    assign step_val = dir_q ? (count_in + 1'b1) : (count_in - 1'b1);
    assign last     = (step_val == target_q);

`ifdef SM_DRIVER_TIMEOUT_EN
    logic wdog_expire;
    logic wdog_clear;
    logic wdog_enable;

    assign wdog_enable = (state == S_ARM) || (state == S_RUN);
    assign wdog_clear  = (next_state == S_ARM) && (state != S_ARM);

    sm_driver_wdog #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wdog_clear),
        .enable(wdog_enable),
        .expire(wdog_expire)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            target_q <= '0;
            dir_q    <= 1'b1;
        end else begin
            state <= next_state;
            if (state == S_IDLE && req_valid) begin
                target_q <= req_target;
                dir_q    <= (req_target > count_in);
            end
        end
    end

    always_comb begin
        next_state = state;
        act        = 1'b0;
        up_dwn_n   = 1'b1;
        req_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    next_state = (req_target == count_in) ? S_CHECK : S_ARM;
                end
            end
            S_ARM: begin
                act        = 1'b1;
                up_dwn_n   = dir_q;
                next_state = S_RUN;
            end
            S_RUN: begin
                act      = !last;
                up_dwn_n = dir_q;
                if (last) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                next_state = (count_in == target_q) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            S_ERR: begin
                err  = 1'b1;
                busy = 1'b0;
            end
            default: begin
                busy       = 1'b0;
                next_state = S_ERR;
            end
        endcase

`ifdef SM_DRIVER_TIMEOUT_EN
        if (wdog_expire) begin
            act        = 1'b0;
            next_state = S_ERR;
        end
`endif

        // A counter overflow overrides everything, including a new request.
        if (ovflw_in) begin
            next_state = S_ERR;
        end
    end

endmodule

// File: tb/tb_sm_driver.sv
// Self-checking bench for sm_driver with a behavioural model of the driven
// up/down counter; covers both builds of SM_DRIVER_TIMEOUT_EN.
module tb_sm_driver;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_target;
    logic       req_ready;
    logic [3:0] count_in;
    logic       ovflw_in;
    logic       act;
    logic       up_dwn_n;
    logic       busy;
    logic       done;
    logic       err;

    // Counter model controls
    logic [3:0] m_count;
    logic       m_up;
    logic       m_dn;
    logic       m_ovf;
    logic       preset_en;
    logic [3:0] preset_val;
    logic       stuck;
    logic       force_ovf;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [3:0] start;
        logic [3:0] target;
        int         act_cycles;
        int         last_act;
        logic       exp_up;
        int         done_cyc;
        logic       poke;
    } vec_t;

    vec_t vecs[8];

    sm_driver #(.COUNTER_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_target(req_target),
        .req_ready (req_ready),
        .count_in  (count_in),
        .ovflw_in  (ovflw_in),
        .act       (act),
        .up_dwn_n  (up_dwn_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: act sampled in cycle k sets its state at edge k+1; a
    // counting state steps the count at the next edge regardless of act.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= 4'd0;
            m_up    <= 1'b0;
            m_dn    <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (preset_en) begin
            m_count <= preset_val;
            m_up    <= 1'b0;
            m_dn    <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            if (!stuck) begin
                if (m_up) begin
                    if (m_count == 4'd15) m_ovf <= 1'b1;
                    m_count <= m_count + 4'd1;
                end else if (m_dn) begin
                    if (m_count == 4'd0) m_ovf <= 1'b1;
                    m_count <= m_count - 4'd1;
                end
            end
            m_up <= act & up_dwn_n;
            m_dn <= act & ~up_dwn_n;
        end
    end

    assign count_in = m_count;
    assign ovflw_in = m_ovf | force_ovf;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic presetCount(input logic [3:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_act"},   int'(act),       0);
        checkOutput({tag, "_up"},    int'(up_dwn_n),  1);
        checkOutput({tag, "_done"},  int'(done),      0);
        checkOutput({tag, "_err"},   int'(err),       0);
        checkOutput({tag, "_busy"},  int'(busy),      0);
        checkOutput({tag, "_ready"}, int'(req_ready), 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Runs one request from a preset count; cycle 0 is the acceptance cycle.
    task automatic applyStimulus(input vec_t v, input int idx);
        int   act_cnt;
        int   last_act;
        int   up1;
        int   done_cyc;
        int   cnt_at_done;
        int   ovf_seen;
        int   ready_bad;
        string tag;
        act_cnt = 0; last_act = 0; up1 = -1; done_cyc = 0;
        cnt_at_done = -1; ovf_seen = 0; ready_bad = 0;
        tag = $sformatf("vec%0d", idx);

        presetCount(v.start);
        req_valid  = 1'b1;
        req_target = v.target;
        checkOutput({tag, "_ready_c0"}, int'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        if (v.poke) begin
            req_valid  = 1'b1;
            req_target = 4'(v.target + 4'd3);
        end
        for (int c = 1; c <= 40; c++) begin
            if (act) begin
                act_cnt++;
                last_act = c;
            end
            if (c == 1) up1 = int'(up_dwn_n);
            if (req_ready) ready_bad = 1;
            if (ovflw_in) ovf_seen = 1;
            if (done) begin
                done_cyc    = c;
                cnt_at_done = int'(count_in);
                break;
            end
            req_valid = 1'b0;
            tick();
        end
        req_valid = 1'b0;
        checkOutput({tag, "_act_cycles"}, act_cnt,     v.act_cycles);
        checkOutput({tag, "_last_act"},   last_act,    v.last_act);
        checkOutput({tag, "_dir"},        up1,         int'(v.exp_up));
        checkOutput({tag, "_done_cyc"},   done_cyc,    v.done_cyc);
        checkOutput({tag, "_count"},      cnt_at_done, int'(v.target));
        checkOutput({tag, "_ovflw"},      ovf_seen,    0);
        checkOutput({tag, "_ready_busy"}, ready_bad,   0);
        tick();
        checkOutput({tag, "_ready_after"}, int'(req_ready), 1);
        checkOutput({tag, "_err"},         int'(err),       0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_target   = 4'd0;
        preset_en    = 1'b0;
        preset_val   = 4'd0;
        stuck        = 1'b0;
        force_ovf    = 1'b0;

        // start, target, act cycles, last act cycle, dir, done cycle, poke
        vecs[0] = '{4'd3,  4'd7,  4,  4,  1'b1, 7,  1'b0};
        vecs[1] = '{4'd9,  4'd2,  7,  7,  1'b0, 10, 1'b0};
        vecs[2] = '{4'd0,  4'd15, 15, 15, 1'b1, 18, 1'b0};
        vecs[3] = '{4'd15, 4'd0,  15, 15, 1'b0, 18, 1'b0};
        vecs[4] = '{4'd5,  4'd5,  0,  0,  1'b1, 2,  1'b1};
        vecs[5] = '{4'd0,  4'd1,  1,  1,  1'b1, 4,  1'b0};
        vecs[6] = '{4'd1,  4'd0,  1,  1,  1'b0, 4,  1'b0};
        vecs[7] = '{4'd14, 4'd3,  11, 11, 1'b0, 14, 1'b0};

        #12;
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Overflow forced mid-RUN: sticky error until reset.
        presetCount(4'd2);
        req_valid  = 1'b1;
        req_target = 4'd12;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkOutput("ovf_in_run_act", int'(act), 1);
        force_ovf = 1'b1;
        tick();
        force_ovf = 1'b0;
        checkOutput("ovf_err",   int'(err),       1);
        checkOutput("ovf_act",   int'(act),       0);
        checkOutput("ovf_ready", int'(req_ready), 0);
        checkOutput("ovf_busy",  int'(busy),      0);
        req_valid  = 1'b1;
        req_target = 4'd1;
        for (int i = 0; i < 5; i++) tick();
        req_valid = 1'b0;
        checkOutput("ovf_err_sticky",   int'(err),       1);
        checkOutput("ovf_ready_sticky", int'(req_ready), 0);
        rst_n = 1'b0;
        #2;
        checkResetValues("ovf_rst");
        rst_n = 1'b1;
        tick();

        // Overflow outranks acceptance in IDLE.
        presetCount(4'd4);
        force_ovf  = 1'b1;
        req_valid  = 1'b1;
        req_target = 4'd9;
        tick();
        force_ovf = 1'b0;
        req_valid = 1'b0;
        checkOutput("idle_ovf_err",  int'(err),  1);
        checkOutput("idle_ovf_busy", int'(busy), 0);
        doReset();

        // Reset mid-RUN drops act without waiting for a clock edge.
        presetCount(4'd0);
        req_valid  = 1'b1;
        req_target = 4'd10;
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("async_pre_act", int'(act), 1);
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        #2;
        rst_n = 1'b1;
        tick();

        // Disconnected counter: count never moves.
        presetCount(4'd0);
        stuck      = 1'b1;
        req_valid  = 1'b1;
        req_target = 4'd4;
        tick();
        req_valid = 1'b0;
`ifdef SM_DRIVER_TIMEOUT_EN
        for (int c = 1; c < 18; c++) tick();
        checkOutput("wdog_c18_err",  int'(err),  0);
        checkOutput("wdog_c18_busy", int'(busy), 1);
        tick();
        checkOutput("wdog_c19_err", int'(err), 1);
        checkOutput("wdog_c19_act", int'(act), 0);
`else
        for (int c = 1; c < 100; c++) tick();
        checkOutput("stall_busy", int'(busy), 1);
        checkOutput("stall_err",  int'(err),  0);
        checkOutput("stall_act",  int'(act),  1);
`endif
        stuck = 1'b0;
        doReset();
        checkResetValues("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
